tone_sequencer: RTL

- Upstream control stage for the speaker-test square-wave path.
- Steps through a fixed 8-note scale table and presents each note's half-period count plus a tone enable to a programmable-period square-wave generator.
- Each note sounds for a fixed duration, followed by a silent gap.
- Runs once per start request, or loops continuously while loop_en is high.

---
 rtl/tone_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a fixed 8-note scale and feeds half-period counts plus a
// tone enable to a downstream square-wave generator, with note/gap timing.
module tone_sequencer #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int NUM_NOTES = 8,
    parameter int NOTE_MS   = 250,
    parameter int GAP_MS    = 20,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop_en,
    output logic             busy,
    output logic             tone_en,
    output logic [CNT_W-1:0] half_period,
    output logic [2:0]       note_idx,
    output logic             done
);

    localparam longint NOTE_CYC = longint'(CLK_FREQ) / 64'sd1000 * longint'(NOTE_MS);
    localparam longint GAP_CYC  = longint'(CLK_FREQ) / 64'sd1000 * longint'(GAP_MS);
    localparam longint CNT_LIM  = 64'sd1 <<< CNT_W;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 64'sd1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 64'sd0) ? CNT_W'(GAP_CYC - 64'sd1)
                                                                 : {CNT_W{1'b0}};
    localparam logic [2:0]       LAST_IDX  = 3'(NUM_NOTES - 1);
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    // Half-period per note: CLK_FREQ / (2 * f), folded to constants at elaboration.
    localparam logic [CNT_W-1:0] HP_TAB [0:7] = '{
        CNT_W'(CLK_FREQ / 32'sd524),
        CNT_W'(CLK_FREQ / 32'sd588),
        CNT_W'(CLK_FREQ / 32'sd660),
        CNT_W'(CLK_FREQ / 32'sd698),
        CNT_W'(CLK_FREQ / 32'sd784),
        CNT_W'(CLK_FREQ / 32'sd880),
        CNT_W'(CLK_FREQ / 32'sd988),
        CNT_W'(CLK_FREQ / 32'sd1046)
    };

    if ((NUM_NOTES < 1) || (NUM_NOTES > 8)) begin : g_bad_num_notes
        $error("tone_sequencer: NUM_NOTES must be in 1..8");
    end
    if (NOTE_CYC < 64'sd1) begin : g_bad_note_cyc
        $error("tone_sequencer: NOTE_CYC must be at least 1");
    end
    if ((NOTE_CYC > CNT_LIM) || (GAP_CYC > CNT_LIM)) begin : g_bad_cnt_w
        $error("tone_sequencer: NOTE_CYC/GAP_CYC do not fit in CNT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q, idx_d;

    state_t           dec_state_s;
    logic [2:0]       dec_idx_s;
    logic             active_s;

    logic             busy_q, busy_d;
    logic             tone_en_q, tone_en_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic [2:0]       note_idx_q, note_idx_d;
    logic             done_q, done_d;

    // End-of-gap decision: advance, wrap for looping, or finish the pass.
    always_comb begin
        dec_state_s = S_DONE;
        dec_idx_s   = 3'd0;
        if (idx_q < LAST_IDX) begin
            dec_state_s = S_PLAY;
            dec_idx_s   = idx_q + 3'd1;
        end else if (loop_en) begin
            dec_state_s = S_PLAY;
            dec_idx_s   = 3'd0;
        end else begin
            dec_state_s = S_DONE;
            dec_idx_s   = 3'd0;
        end
    end

    // Sequencer next-state and duration timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PLAY;
                    timer_d = {CNT_W{1'b0}};
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (timer_q == NOTE_LAST) begin
                    timer_d = {CNT_W{1'b0}};
                    // With no gap configured the next note starts straight away.
                    if (GAP_CYC > 64'sd0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = dec_state_s;
                        idx_d   = dec_idx_s;
                    end
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = {CNT_W{1'b0}};
                    state_d = dec_state_s;
                    idx_d   = dec_idx_s;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                timer_d = {CNT_W{1'b0}};
                idx_d   = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = {CNT_W{1'b0}};
                idx_d   = 3'd0;
            end
        endcase
    end

    // Output values derived from the current sequencer state.
    always_comb begin
        active_s  = (state_q == S_PLAY) || (state_q == S_GAP);
        busy_d    = active_s;
        tone_en_d = (state_q == S_PLAY);
        done_d    = (state_q == S_DONE);
        if (active_s) begin
            half_period_d = HP_TAB[idx_q];
            note_idx_d    = idx_q;
        end else begin
            half_period_d = {CNT_W{1'b0}};
            note_idx_d    = 3'd0;
        end
    end

    // State, timer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= {CNT_W{1'b0}};
            idx_q         <= 3'd0;
            busy_q        <= 1'b0;
            tone_en_q     <= 1'b0;
            half_period_q <= {CNT_W{1'b0}};
            note_idx_q    <= 3'd0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            tone_en_q     <= tone_en_d;
            half_period_q <= half_period_d;
            note_idx_q    <= note_idx_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign tone_en     = tone_en_q;
    assign half_period = half_period_q;
    assign note_idx    = note_idx_q;
    assign done        = done_q;

endmodule
